// File: rtl/am2910_gen_pkg.sv
// Shared types for the am2910_gen microprogram sequencer: opcodes and stack operations.
package am2910_gen_pkg;

  typedef enum logic [3:0] {
    OP_JZ   = 4'd0,
    OP_CJS  = 4'd1,
    OP_JMAP = 4'd2,
    OP_CJP  = 4'd3,
    OP_PUSH = 4'd4,
    OP_JSRP = 4'd5,
    OP_CJV  = 4'd6,
    OP_JRP  = 4'd7,
    OP_RFCT = 4'd8,
    OP_RPCT = 4'd9,
    OP_CRTN = 4'd10,
    OP_CJPP = 4'd11,
    OP_LDCT = 4'd12,
    OP_LOOP = 4'd13,
    OP_CONT = 4'd14,
    OP_TWB  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    STK_NONE,
    STK_PUSH,
    STK_POP,
    STK_CLEAR
  } stack_op_e;

endpackage

// File: rtl/am2910_gen_stack.sv
// Subroutine/loop stack for am2910_gen; a push when full overwrites the top entry.
// Sticky overflow/underflow flags exist only when AM2910_GEN_STACK_ERR_EN is defined.
module am2910_gen_stack
  import am2910_gen_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  stack_op_e     i_op,
  input  logic [AW-1:0] i_data,
  output logic [AW-1:0] o_tos,
  output logic          o_full,
  output logic          o_empty
`ifdef AM2910_GEN_STACK_ERR_EN
  ,
  output logic          o_ovf,
  output logic          o_unf
`endif
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

  logic [AW-1:0]  r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [SPW-1:0] w_rdIdx;
  logic [SPW-1:0] w_wrIdx;

  assign o_full  = (r_sp == SP_FULL);
  assign o_empty = (r_sp == '0);
  // An empty stack still reads entry 0, so a stray return lands on its last value.
  assign w_rdIdx = o_empty ? '0 : r_sp - SP_ONE;
  assign w_wrIdx = o_full ? r_sp - SP_ONE : r_sp;

  always_comb begin
    o_tos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rdIdx == SPW'(i)) o_tos = r_mem[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (i_op)
        STK_CLEAR: r_sp <= '0;
        STK_PUSH: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (w_wrIdx == SPW'(i)) r_mem[i] <= i_data;
          end
          if (!o_full) r_sp <= r_sp + SP_ONE;
        end
        STK_POP: if (!o_empty) r_sp <= r_sp - SP_ONE;
        default: ;
      endcase
    end
  end

`ifdef AM2910_GEN_STACK_ERR_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (i_op == STK_CLEAR) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (i_op == STK_PUSH && o_full) r_ovf <= 1'b1;
      if (i_op == STK_POP && o_empty) r_unf <= 1'b1;
    end
  end

  assign o_ovf = r_ovf;
  assign o_unf = r_unf;
`endif

endmodule

// File: rtl/am2910_gen.sv
// Parametrised Am2910-style microprogram sequencer: decode, microPC, register/counter and y mux.
// Define AM2910_GEN_STACK_ERR_EN to add the sticky stk_ovf/stk_unf outputs.
module am2910_gen
  import am2910_gen_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] di,
  input  logic [3:0]    instr,
  input  logic          ccn,
  input  logic          ccen,
  input  logic          rldn,
  input  logic          ci,
  output logic [AW-1:0] y,
  output logic          fulln,
  output logic          emptyn,
  output logic          pln,
  output logic          mapn,
  output logic          vectn
`ifdef AM2910_GEN_STACK_ERR_EN
  ,
  output logic          stk_ovf,
  output logic          stk_unf
`endif
);

  logic [AW-1:0] r_upc;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_y;
  logic [AW-1:0] w_tos;
  logic          w_pass;
  logic          w_cntZero;
  logic          w_loadCnt;
  logic          w_decCnt;
  logic          w_pln;
  logic          w_mapn;
  logic          w_vectn;
  logic          w_full;
  logic          w_empty;
  stack_op_e     w_stkOp;

  assign w_pass    = ~ccen | ~ccn;
  assign w_cntZero = (r_cnt == '0);

  always_comb begin
    w_y       = r_upc;
    w_stkOp   = STK_NONE;
    w_loadCnt = 1'b0;
    w_decCnt  = 1'b0;
    w_pln     = 1'b0;
    w_mapn    = 1'b1;
    w_vectn   = 1'b1;
    case (opcode_e'(instr))
      OP_JZ: begin
        w_y     = '0;
        w_stkOp = STK_CLEAR;
      end
      OP_CJS: if (w_pass) begin
        w_y     = di;
        w_stkOp = STK_PUSH;
      end
      OP_JMAP: begin
        w_y    = di;
        w_pln  = 1'b1;
        w_mapn = 1'b0;
      end
      OP_CJP: if (w_pass) w_y = di;
      OP_PUSH: begin
        w_stkOp   = STK_PUSH;
        w_loadCnt = w_pass;
      end
      OP_JSRP: begin
        w_y     = w_pass ? di : r_cnt;
        w_stkOp = STK_PUSH;
      end
      OP_CJV: begin
        if (w_pass) w_y = di;
        w_pln   = 1'b1;
        w_vectn = 1'b0;
      end
      OP_JRP: w_y = w_pass ? di : r_cnt;
      OP_RFCT: begin
        if (!w_cntZero) begin
          w_y      = w_tos;
          w_decCnt = 1'b1;
        end else begin
          w_stkOp = STK_POP;
        end
      end
      OP_RPCT: if (!w_cntZero) begin
        w_y      = di;
        w_decCnt = 1'b1;
      end
      OP_CRTN: if (w_pass) begin
        w_y     = w_tos;
        w_stkOp = STK_POP;
      end
      OP_CJPP: if (w_pass) begin
        w_y     = di;
        w_stkOp = STK_POP;
      end
      OP_LDCT: w_loadCnt = 1'b1;
      OP_LOOP: begin
        if (w_pass) w_stkOp = STK_POP;
        else        w_y     = w_tos;
      end
      OP_TWB: begin
        // Only "counter running and condition failing" keeps the loop alive.
        if (!w_cntZero && !w_pass) begin
          w_y      = w_tos;
          w_decCnt = 1'b1;
        end else begin
          w_stkOp = STK_POP;
          if (w_cntZero && !w_pass) w_y = di;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upc <= '0;
      r_cnt <= '0;
    end else begin
      r_upc <= w_y + AW'(ci);
      if (!rldn || w_loadCnt) r_cnt <= di;
      else if (w_decCnt)      r_cnt <= r_cnt - AW'(1);
    end
  end

  am2910_gen_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_op    (w_stkOp),
    .i_data  (r_upc),
    .o_tos   (w_tos),
    .o_full  (w_full),
    .o_empty (w_empty)
`ifdef AM2910_GEN_STACK_ERR_EN
    ,
    .o_ovf   (stk_ovf),
    .o_unf   (stk_unf)
`endif
  );

  // Address bus and source enables are held at their idle values during reset.
  assign y      = rst_n ? w_y : '0;
  assign pln    = rst_n ? w_pln : 1'b0;
  assign mapn   = rst_n ? w_mapn : 1'b1;
  assign vectn  = rst_n ? w_vectn : 1'b1;
  assign fulln  = ~w_full;
  assign emptyn = ~w_empty;

endmodule

// File: tb/tb_am2910_gen.sv
// Self-checking bench for am2910_gen: directed vector table, hand sequences and a
// random run against a queue-based sequencer model.
module tb_am2910_gen;

  localparam int AW    = 12;
  localparam int DEPTH = 5;
  localparam int unsigned MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] di;
  logic [3:0]    instr;
  logic          ccn, ccen, rldn, ci;
  logic [AW-1:0] y;
  logic          fulln, emptyn, pln, mapn, vectn;
`ifdef AM2910_GEN_STACK_ERR_EN
  logic          stkOvf, stkUnf;
`endif

  am2910_gen #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .di     (di),
    .instr  (instr),
    .ccn    (ccn),
    .ccen   (ccen),
    .rldn   (rldn),
    .ci     (ci),
    .y      (y),
    .fulln  (fulln),
    .emptyn (emptyn),
    .pln    (pln),
    .mapn   (mapn),
    .vectn  (vectn)
`ifdef AM2910_GEN_STACK_ERR_EN
    ,
    .stk_ovf(stkOvf),
    .stk_unf(stkUnf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: the stack is a plain queue, entry 0 remembered separately.
  int unsigned mUpc, mR, mEntry0;
  int unsigned mStk[$];
  bit          mOvf, mUnf;

  // Predictions for the cycle in progress.
  int unsigned pY;
  bit          pPln, pMapn, pVectn, pLoad, pDec;
  int          pOp;  // 0 none, 1 push, 2 pop, 3 clear

  typedef struct {
    logic [3:0]    instr;
    logic [AW-1:0] di;
    logic          ccn, ccen, rldn, ci;
    logic [AW-1:0] expY;
    logic          expPln, expMapn, expVectn, expEmptyn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int ins, input int d, input bit c, input bit ce,
                              input bit rl, input bit cin, input int ey,
                              input bit ep, input bit em, input bit ev, input bit ee);
    vec_t v;
    v.instr = 4'(ins); v.di = AW'(d); v.ccn = c; v.ccen = ce; v.rldn = rl; v.ci = cin;
    v.expY = AW'(ey); v.expPln = ep; v.expMapn = em; v.expVectn = ev; v.expEmptyn = ee;
    return v;
  endfunction

  function automatic void modelReset();
    mUpc = 0; mR = 0; mEntry0 = 0; mStk.delete(); mOvf = 0; mUnf = 0;
  endfunction

  function automatic int unsigned modelTos();
    return (mStk.size() == 0) ? mEntry0 : mStk[mStk.size() - 1];
  endfunction

  function automatic void modelPredict(input int ins, input int unsigned d, input bit c, input bit ce);
    bit pass = !ce || !c;
    bit rz = (mR == 0);
    pY = mUpc; pOp = 0; pLoad = 0; pDec = 0; pPln = 0; pMapn = 1; pVectn = 1;
    case (ins)
      0:  begin pY = 0; pOp = 3; end
      1:  if (pass) begin pY = d; pOp = 1; end
      2:  begin pY = d; pPln = 1; pMapn = 0; end
      3:  if (pass) pY = d;
      4:  begin pOp = 1; pLoad = pass; end
      5:  begin pY = pass ? d : mR; pOp = 1; end
      6:  begin if (pass) pY = d; pPln = 1; pVectn = 0; end
      7:  pY = pass ? d : mR;
      8:  if (!rz) begin pY = modelTos(); pDec = 1; end else pOp = 2;
      9:  if (!rz) begin pY = d; pDec = 1; end
      10: if (pass) begin pY = modelTos(); pOp = 2; end
      11: if (pass) begin pY = d; pOp = 2; end
      12: pLoad = 1;
      13: if (pass) pOp = 2; else pY = modelTos();
      14: ;
      default: begin
        if (!rz && !pass) begin pY = modelTos(); pDec = 1; end
        else if (!rz) pOp = 2;
        else begin pOp = 2; if (!pass) pY = d; end
      end
    endcase
  endfunction

  function automatic void modelCommit(input int unsigned d, input bit rl, input bit cin);
    case (pOp)
      1: begin
        if (mStk.size() == DEPTH) begin
          mStk[DEPTH - 1] = mUpc;
          mOvf = 1;
        end else begin
          if (mStk.size() == 0) mEntry0 = mUpc;
          mStk.push_back(mUpc);
        end
      end
      2: if (mStk.size() == 0) mUnf = 1; else void'(mStk.pop_back());
      3: begin mStk.delete(); mOvf = 0; mUnf = 0; end
      default: ;
    endcase
    if (!rl || pLoad) mR = d & MASK;
    else if (pDec)    mR = (mR - 1) & MASK;
    mUpc = (pY + cin) & MASK;
  endfunction

  logic [AW-1:0] curDi;
  logic          curRldn, curCi;

  // Drive one instruction just after a rising edge and wait for the falling edge.
  task automatic applyStimulus(input int ins, input int unsigned d, input bit c,
                               input bit ce, input bit rl, input bit cin);
    instr = 4'(ins); di = AW'(d); ccn = c; ccen = ce; rldn = rl; ci = cin;
    curDi = AW'(d); curRldn = rl; curCi = cin;
    modelPredict(ins, d & MASK, c, ce);
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    modelCommit(curDi, curRldn, curCi);
  endtask

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, " y"}, y, pY);
    checkOutput({tag, " pln"}, pln, pPln);
    checkOutput({tag, " mapn"}, mapn, pMapn);
    checkOutput({tag, " vectn"}, vectn, pVectn);
    checkOutput({tag, " fulln"}, fulln, mStk.size() != DEPTH);
    checkOutput({tag, " emptyn"}, emptyn, mStk.size() != 0);
`ifdef AM2910_GEN_STACK_ERR_EN
    checkOutput({tag, " stk_ovf"}, stkOvf, mOvf);
    checkOutput({tag, " stk_unf"}, stkUnf, mUnf);
`endif
  endtask

  initial begin
    // Directed table: {instr, di, ccn, ccen, rldn, ci, y, pln, mapn, vectn, emptyn}
    vecs.push_back(mk(14, 'h000, 1, 1, 1, 1, 'h000, 0, 1, 1, 0));
    vecs.push_back(mk(14, 'h000, 1, 1, 1, 1, 'h001, 0, 1, 1, 0));
    vecs.push_back(mk(14, 'h000, 1, 1, 1, 1, 'h002, 0, 1, 1, 0));
    vecs.push_back(mk(14, 'h000, 1, 1, 1, 1, 'h003, 0, 1, 1, 0));
    vecs.push_back(mk( 3, 'h004, 0, 1, 1, 1, 'h004, 0, 1, 1, 0));
    vecs.push_back(mk( 1, 'h120, 0, 1, 1, 1, 'h120, 0, 1, 1, 0));
    vecs.push_back(mk(10, 'h000, 0, 1, 1, 1, 'h005, 0, 1, 1, 1));
    vecs.push_back(mk(14, 'h000, 1, 1, 1, 1, 'h006, 0, 1, 1, 0));
    vecs.push_back(mk(12, 'h002, 1, 1, 1, 1, 'h007, 0, 1, 1, 0));
    vecs.push_back(mk( 4, 'h055, 1, 1, 1, 1, 'h008, 0, 1, 1, 0));
    vecs.push_back(mk( 8, 'h000, 1, 1, 1, 1, 'h008, 0, 1, 1, 1));
    vecs.push_back(mk( 8, 'h000, 1, 1, 1, 1, 'h008, 0, 1, 1, 1));
    vecs.push_back(mk( 8, 'h000, 1, 1, 1, 1, 'h009, 0, 1, 1, 1));
    vecs.push_back(mk(14, 'h000, 1, 1, 1, 1, 'h00A, 0, 1, 1, 0));
    vecs.push_back(mk( 6, 'h03F, 1, 0, 1, 1, 'h03F, 1, 1, 0, 0));
    vecs.push_back(mk( 2, 'h200, 1, 1, 1, 1, 'h200, 1, 0, 1, 0));
    vecs.push_back(mk( 3, 'h300, 1, 1, 1, 1, 'h201, 0, 1, 1, 0));
    vecs.push_back(mk( 7, 'h400, 1, 1, 1, 1, 'h000, 0, 1, 1, 0));
    vecs.push_back(mk(12, 'h003, 1, 1, 1, 1, 'h001, 0, 1, 1, 0));
    vecs.push_back(mk( 9, 'h050, 1, 1, 1, 1, 'h050, 0, 1, 1, 0));
    vecs.push_back(mk( 9, 'h050, 1, 1, 0, 1, 'h050, 0, 1, 1, 0));
    vecs.push_back(mk( 7, 'h111, 1, 1, 1, 1, 'h050, 0, 1, 1, 0));
    vecs.push_back(mk( 0, 'h000, 1, 1, 1, 1, 'h000, 0, 1, 1, 0));
    vecs.push_back(mk( 5, 'h222, 1, 1, 1, 1, 'h050, 0, 1, 1, 0));
    vecs.push_back(mk(13, 'h000, 1, 1, 1, 1, 'h001, 0, 1, 1, 1));
    vecs.push_back(mk(13, 'h000, 0, 1, 1, 1, 'h002, 0, 1, 1, 1));
    vecs.push_back(mk(11, 'h0AA, 0, 1, 1, 1, 'h0AA, 0, 1, 1, 0));
    vecs.push_back(mk(10, 'h000, 0, 1, 1, 1, 'h001, 0, 1, 1, 0));
    vecs.push_back(mk(12, 'h001, 1, 1, 1, 1, 'h002, 0, 1, 1, 0));
    vecs.push_back(mk( 3, 'h023, 0, 1, 1, 1, 'h023, 0, 1, 1, 0));
    vecs.push_back(mk( 4, 'h000, 1, 1, 1, 1, 'h024, 0, 1, 1, 0));
    vecs.push_back(mk(15, 'h001, 1, 1, 1, 1, 'h024, 0, 1, 1, 1));
    vecs.push_back(mk(15, 'h001, 1, 1, 1, 1, 'h001, 0, 1, 1, 1));
    vecs.push_back(mk(14, 'h000, 1, 1, 1, 1, 'h002, 0, 1, 1, 0));
    vecs.push_back(mk(14, 'h000, 1, 1, 1, 0, 'h003, 0, 1, 1, 0));
    vecs.push_back(mk(14, 'h000, 1, 1, 1, 1, 'h003, 0, 1, 1, 0));

    // Reset with a passing CJP presented: y must still read zero.
    rst_n = 1'b0; instr = 4'd3; di = 'hABC; ccn = 0; ccen = 1; rldn = 1; ci = 1;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset y", y, 0);
    checkOutput("reset emptyn", emptyn, 0);
    checkOutput("reset fulln", fulln, 1);
    checkOutput("reset pln", pln, 0);
    checkOutput("reset mapn", mapn, 1);
    checkOutput("reset vectn", vectn, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].instr, vecs[i].di, vecs[i].ccn, vecs[i].ccen, vecs[i].rldn, vecs[i].ci);
      checkOutput($sformatf("vec%0d y", i), y, vecs[i].expY);
      checkOutput($sformatf("vec%0d pln", i), pln, vecs[i].expPln);
      checkOutput($sformatf("vec%0d mapn", i), mapn, vecs[i].expMapn);
      checkOutput($sformatf("vec%0d vectn", i), vectn, vecs[i].expVectn);
      checkOutput($sformatf("vec%0d emptyn", i), emptyn, vecs[i].expEmptyn);
      checkOutput($sformatf("vec%0d fulln", i), fulln, 1);
      advance();
    end

    // Overflow: JZ then six pushes of upc 1..6; the sixth overwrites the top.
    applyStimulus(0, 0, 1, 1, 1, 1);
    checkAgainstModel("ovf jz");
    advance();
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(4, 0, 1, 1, 1, 1);
      checkOutput($sformatf("ovf push%0d y", k), y, k);
      checkAgainstModel($sformatf("ovf push%0d", k));
      advance();
    end
    applyStimulus(10, 0, 0, 1, 1, 1);
    checkOutput("ovf tos", y, 6);
    checkOutput("ovf fulln", fulln, 0);
`ifdef AM2910_GEN_STACK_ERR_EN
    checkOutput("ovf flag", stkOvf, 1);
`endif
    advance();
    applyStimulus(0, 0, 1, 1, 1, 1);
    checkAgainstModel("ovf clear");
    advance();
    applyStimulus(14, 0, 1, 1, 1, 1);
    checkOutput("clear emptyn", emptyn, 0);
`ifdef AM2910_GEN_STACK_ERR_EN
    checkOutput("clear ovf flag", stkOvf, 0);
`endif
    advance();

    // Reset in the middle of an RFCT loop abandons counter and stack at once.
    applyStimulus(12, 5, 1, 1, 1, 1); advance();
    applyStimulus(4, 0, 1, 1, 1, 1); advance();
    applyStimulus(8, 0, 1, 1, 1, 1);
    checkAgainstModel("loop rfct");
    advance();
    rst_n = 1'b0;
    #2;
    checkOutput("midloop reset y", y, 0);
    checkOutput("midloop reset emptyn", emptyn, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    applyStimulus(14, 0, 1, 1, 1, 1);
    checkOutput("post reset y", y, 0);
    advance();
    applyStimulus(8, 0, 1, 1, 1, 1);
    checkOutput("post reset rfct y", y, 1);
    checkAgainstModel("post reset rfct");
    advance();

    // Random run against the model; small di values often so counters hit zero.
    for (int n = 0; n < 400; n++) begin
      int unsigned d;
      d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : ($urandom & MASK);
      applyStimulus($urandom_range(0, 15), d, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 7) != 0));
      checkAgainstModel($sformatf("rand%0d", n));
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
